// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x,y) -> atan2 phase in turn units plus magnitude.
// Optional magnitude output enabled by defining CORDIC_VECTOR_MAG_EN (otherwise mag is tied to 0).
module cordic_vector #(
  parameter int ITER       = 16,
  parameter int GAIN_RECIP = 39797
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               in_valid,
  input  logic signed [15:0] x,
  input  logic signed [15:0] y,
  output logic               ready,
  output logic               out_valid,
  output logic        [15:0] theta,
  output logic        [16:0] mag,
  output logic               zero
);

  if (ITER < 1 || ITER > 16) begin : g_bad_iter
    $error("cordic_vector: ITER must be 1..16");
  end
  if (GAIN_RECIP < 1 || GAIN_RECIP > 65535) begin : g_bad_gain
    $error("cordic_vector: GAIN_RECIP must fit in Q0.16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ITER = 2'b01
  } state_t;

  state_t             state;
  logic        [4:0]  iter;
  logic signed [17:0] xr;
  logic signed [17:0] yr;
  logic signed [17:0] z;
  logic        [1:0]  quad;
  logic               zin;

  logic signed [17:0] x_ext;
  logic signed [17:0] y_ext;
  logic signed [17:0] x_abs;
  logic signed [17:0] y_abs;
  logic signed [17:0] x_sh;
  logic signed [17:0] y_sh;
  logic signed [17:0] gamma;

  // atan(2^-i) with a quarter turn scaled to 2^16
  function automatic logic signed [17:0] gamma_mem(input logic [3:0] idx);
    case (idx)
      4'd0:    return 18'sd32768;
      4'd1:    return 18'sd19344;
      4'd2:    return 18'sd10221;
      4'd3:    return 18'sd5188;
      4'd4:    return 18'sd2604;
      4'd5:    return 18'sd1303;
      4'd6:    return 18'sd652;
      4'd7:    return 18'sd326;
      4'd8:    return 18'sd163;
      4'd9:    return 18'sd81;
      4'd10:   return 18'sd41;
      4'd11:   return 18'sd20;
      4'd12:   return 18'sd10;
      4'd13:   return 18'sd5;
      4'd14:   return 18'sd3;
      default: return 18'sd1;
    endcase
  endfunction

  // First-quadrant angle rounded to turn units and clamped, then unfolded by quadrant
  function automatic logic [15:0] fold_theta(input logic [1:0] q, input logic signed [17:0] zv);
    logic signed [18:0] r;
    logic        [16:0] a;
    logic        [16:0] t;
    r = $signed({zv[17], zv}) + 19'sd2;
    r = r >>> 2;
    if (r < 19'sd0)
      a = 17'd0;
    else if (r > 19'sd16384)
      a = 17'h04000;
    else
      a = r[16:0];
    case (q)
      2'd0:    t = a;
      2'd1:    t = 17'h08000 - a;
      2'd2:    t = 17'h08000 + a;
      default: t = 17'h10000 - a;
    endcase
    return t[15:0];
  endfunction

`ifdef CORDIC_VECTOR_MAG_EN
  // Remove the CORDIC gain and saturate to the 17-bit unsigned output
  function automatic logic [16:0] sat_mag(input logic signed [17:0] xv);
    logic [34:0] p;
    logic [18:0] s;
    if (xv[17])
      return 17'd0;
    p = 35'(xv[16:0]) * 35'(GAIN_RECIP);
    s = 19'(p >> 16);
    if (s[18:17] != 2'b00)
      return 17'h1FFFF;
    return s[16:0];
  endfunction
`endif

  always_comb begin
    x_ext = {{2{x[15]}}, x};
    y_ext = {{2{y[15]}}, y};
    x_abs = x_ext[17] ? -x_ext : x_ext;
    y_abs = y_ext[17] ? -y_ext : y_ext;
    x_sh  = xr >>> iter;
    y_sh  = yr >>> iter;
    gamma = gamma_mem(iter[3:0]);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      iter      <= 5'd0;
      xr        <= '0;
      yr        <= '0;
      z         <= '0;
      quad      <= 2'd0;
      zin       <= 1'b0;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      theta     <= '0;
      mag       <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (in_valid && ready) begin
            quad  <= {y[15], x[15] ^ y[15]};
            xr    <= x_abs;
            yr    <= y_abs;
            z     <= '0;
            zin   <= (x == 16'sd0) && (y == 16'sd0);
            iter  <= 5'd0;
            ready <= 1'b0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          if (iter == 5'(ITER)) begin
            // Finalise: fold the angle back out of the first quadrant
            theta <= zin ? 16'd0 : fold_theta(quad, z);
`ifdef CORDIC_VECTOR_MAG_EN
            mag   <= zin ? 17'd0 : sat_mag(xr);
`else
            mag   <= 17'd0;
`endif
            zero      <= zin;
            out_valid <= 1'b1;
            ready     <= 1'b1;
            iter      <= 5'd0;
            state     <= S_IDLE;
          end else begin
            if (!yr[17]) begin
              xr <= xr + y_sh;
              yr <= yr - x_sh;
              z  <= z + gamma;
            end else begin
              xr <= xr - y_sh;
              yr <= yr + x_sh;
              z  <= z - gamma;
            end
            iter <= iter + 5'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          iter      <= 5'd0;
          xr        <= '0;
          yr        <= '0;
          z         <= '0;
          quad      <= 2'd0;
          zin       <= 1'b0;
          ready     <= 1'b1;
          out_valid <= 1'b0;
          theta     <= '0;
          mag       <= '0;
          zero      <= 1'b0;
        end
      endcase
    end
  end

endmodule
